eth_frame_tx_arb: RTL

Round-robin arbiter that shares the single `eth_axis_tx` Ethernet-frame input (header handshake plus payload AXI-stream) between `PORTS` frame sources, such as the test pattern generator, the DPA pattern generator and the loopback path. It grants one whole frame at a time: header, then payload through `tlast`. The grant is held until the frame completes, so frames from different sources never interleave. It sits between the frame sources and `eth_axis_tx` in the MAC core, in the `clk` domain.

---
 rtl/eth_frame_tx_arb.sv | 134 +++++++++++++
 1 files changed

// File: rtl/eth_frame_tx_arb.sv
// rtl/eth_frame_tx_arb.sv - round-robin whole-frame arbiter feeding eth_axis_tx
// Header handshake plus payload stream are switched per frame; grant is held through tlast.
module eth_frame_tx_arb #(
  parameter int PORTS      = 2,
  parameter int DATA_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [PORTS-1:0]            s_eth_hdr_valid,
  output logic [PORTS-1:0]            s_eth_hdr_ready,
  input  logic [PORTS*48-1:0]         s_eth_dest_mac,
  input  logic [PORTS*48-1:0]         s_eth_src_mac,
  input  logic [PORTS*16-1:0]         s_eth_type,
  input  logic [PORTS*DATA_WIDTH-1:0] s_eth_payload_axis_tdata,
  input  logic [PORTS-1:0]            s_eth_payload_axis_tvalid,
  input  logic [PORTS-1:0]            s_eth_payload_axis_tlast,
  input  logic [PORTS-1:0]            s_eth_payload_axis_tuser,
  output logic [PORTS-1:0]            s_eth_payload_axis_tready,
  output logic                        m_eth_hdr_valid,
  input  logic                        m_eth_hdr_ready,
  output logic [47:0]                 m_eth_dest_mac,
  output logic [47:0]                 m_eth_src_mac,
  output logic [15:0]                 m_eth_type,
  output logic [DATA_WIDTH-1:0]       m_eth_payload_axis_tdata,
  output logic                        m_eth_payload_axis_tvalid,
  output logic                        m_eth_payload_axis_tlast,
  output logic                        m_eth_payload_axis_tuser,
  input  logic                        m_eth_payload_axis_tready,
  output logic [PORTS-1:0]            grant,
  output logic                        busy,
  output logic [31:0]                 frame_count
);

  localparam int IW = (PORTS > 1) ? $clog2(PORTS) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_PAYLOAD} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IW-1:0]    r_last;
  logic [PORTS-1:0] r_grant;
  logic [31:0]      r_frame_count;

  logic [IW-1:0]    w_sel;
  logic [IW-1:0]    w_cand;
  logic             w_found;
  logic             w_g_hdr_valid;
  logic             w_g_tvalid;
  logic             w_g_tlast;
  logic             w_hdr_hs;
  logic             w_eof_hs;

  // r_last doubles as the owner index: it only changes on a grant, so it always names port g.
  always_comb begin
    w_g_hdr_valid             = 1'b0;
    w_g_tvalid                = 1'b0;
    w_g_tlast                 = 1'b0;
    m_eth_dest_mac            = '0;
    m_eth_src_mac             = '0;
    m_eth_type                = '0;
    m_eth_payload_axis_tdata  = '0;
    m_eth_payload_axis_tuser  = 1'b0;
    s_eth_hdr_ready           = '0;
    s_eth_payload_axis_tready = '0;
    for (int i = 0; i < PORTS; i++) begin
      if (r_last == IW'(i)) begin
        w_g_hdr_valid                = s_eth_hdr_valid[i];
        w_g_tvalid                   = s_eth_payload_axis_tvalid[i];
        w_g_tlast                    = s_eth_payload_axis_tlast[i];
        m_eth_dest_mac               = s_eth_dest_mac[i*48 +: 48];
        m_eth_src_mac                = s_eth_src_mac[i*48 +: 48];
        m_eth_type                   = s_eth_type[i*16 +: 16];
        m_eth_payload_axis_tdata     = s_eth_payload_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        m_eth_payload_axis_tuser     = s_eth_payload_axis_tuser[i];
        s_eth_hdr_ready[i]           = (r_state == ST_HDR) && m_eth_hdr_ready;
        s_eth_payload_axis_tready[i] = (r_state == ST_PAYLOAD) && m_eth_payload_axis_tready;
      end
    end
  end

  // Search upward from last+1 so the port that just finished is considered last.
  always_comb begin
    w_found = 1'b0;
    w_sel   = r_last;
    w_cand  = r_last;
    for (int k = 1; k <= PORTS; k++) begin
      w_cand = IW'((int'(r_last) + k) % PORTS);
      if (!w_found && s_eth_hdr_valid[w_cand]) begin
        w_found = 1'b1;
        w_sel   = w_cand;
      end
    end
  end

  assign m_eth_hdr_valid           = (r_state == ST_HDR) && w_g_hdr_valid;
  assign m_eth_payload_axis_tvalid = (r_state == ST_PAYLOAD) && w_g_tvalid;
  assign m_eth_payload_axis_tlast  = w_g_tlast;
  assign w_hdr_hs                  = m_eth_hdr_valid && m_eth_hdr_ready;
  assign w_eof_hs                  = m_eth_payload_axis_tvalid && m_eth_payload_axis_tready && w_g_tlast;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (w_found)  w_state_nxt = ST_HDR;
      ST_HDR:     if (w_hdr_hs) w_state_nxt = ST_PAYLOAD;
      ST_PAYLOAD: if (w_eof_hs) w_state_nxt = ST_IDLE;
      default:                  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_last        <= IW'(PORTS - 1);
      r_grant       <= '0;
      r_frame_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IDLE && w_found) begin
        r_last  <= w_sel;
        r_grant <= {{(PORTS-1){1'b0}}, 1'b1} << w_sel;
      end
      if (w_eof_hs) begin
        r_frame_count <= r_frame_count + 32'd1;
        r_grant       <= '0;
      end
    end
  end

  assign grant       = r_grant;
  assign busy        = (r_state != ST_IDLE);
  assign frame_count = r_frame_count;

endmodule
